mult_scheduler: RTL and testbench
=================================

Name: mult_scheduler

Overview:
Shares one combinational N×N `multiplier` instance between R requesters using round-robin arbitration. Operands are registered on grant, the product is captured one cycle later, and the result is returned with a valid/ready response handshake. The block sits between the operand sources and any consumer of products, and it is the only block that drives the shared multiplier.

Parameters:
N, 4, operand width in bits; product width is 2*N.
R, 2, number of requesters (R >= 2); ID width IW = $clog2(R).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  R  requester i presents operands.
req_a  in  R*N  operand a; requester i uses bits [i*N +: N].
req_b  in  R*N  operand b; requester i uses bits [i*N +: N].
req_ready  out  R  one-hot grant; request accepted on the edge where req_valid[i] & req_ready[i].
rsp_valid  out  1  result available.
rsp_id  out  IW  index of the requester that owns the result.
rsp_product  out  2*N  unsigned product a*b.
rsp_ready  in  1  consumer accepts the result.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - rst immediately forces state=IDLE, rr_ptr=0, op registers=0.
  - Output reset values: rsp_valid=0, rsp_id=0, rsp_product=0, busy=0. req_ready follows combinationally from IDLE.
  - Reset mid-operation discards the in-flight request; no response is produced.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: the grant index g is the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod R.
    - req_ready = onehot(g) when any req_valid=1, else 0. req_ready is 0 in every other state.
    - On accept: latch a_r, b_r and id_r=g; set rr_ptr=(g+1) mod R; go to EXEC.
  - EXEC: the multiplier sees a_r, b_r.
    - At the next edge: rsp_product <= multiplier output, rsp_id <= id_r, rsp_valid <= 1; go to DONE.
  - DONE: rsp_valid=1, and rsp_product and rsp_id are held stable.
    - On rsp_valid & rsp_ready: rsp_valid <= 0; go to IDLE.
    - A new grant is possible only in the following IDLE cycle.
- Latency: accept edge E0, EXEC edge E1; rsp_valid is high after E1.
- Throughput: at best one result per 3 cycles.
- Requester obligations: hold req_valid, req_a and req_b stable until accepted. The block must not depend on operand values before the grant.
- req_valid for i≠g is ignored and left pending.
- Arithmetic: unsigned; full 2N-bit product with no truncation (15*15=225 at N=4). No '*' operator in this block; the multiplication is done by the `multiplier` instance.
- Boundary conditions:
  - All req_valid=0 in IDLE: stay in IDLE; rr_ptr unchanged.
  - rsp_ready held high while entering DONE: the response completes in a single DONE cycle.
  - rsp_ready asserted outside DONE: ignored.
  - rr_ptr wraps from R-1 to 0.
  - Continuous requests from all requesters are granted strictly in rotation 0,1,...,R-1,0.

Optional Feature:
Macro MULT_SCHED_ZERO_BYPASS_EN.
- Defined: on accept, if the selected a==0 or b==0, skip EXEC.
  - Go directly to DONE with rsp_product=0 and rsp_id=g, registered at E0.
  - rsp_valid is high after E0, one cycle earlier than normal.
  - rr_ptr update is unchanged.
- Undefined: every request passes through EXEC with uniform 2-edge latency, including zero operands.

Test Plan:
1. N=4, R=2; req_valid=01, a0=13, b0=11 → req_ready=01 for one cycle; rsp_valid after 2 edges, rsp_product=143, rsp_id=0, busy=1 until the response handshake.
2. Both valid from reset: (a0=15, b0=15), (a1=3, b1=5), each re-presented after acceptance → responses in order id 0 (225), id 1 (15), id 0, id 1; never two consecutive grants to the same id.
3. Backpressure: result 6*7 reaches DONE with rsp_ready=0 for 5 cycles → rsp_valid=1, rsp_product=42, rsp_id stable; req_ready=00 throughout; IDLE one cycle after rsp_ready=1.
4. Assert rst during EXEC of request 9*9 → rsp_valid=0, rsp_product=0, busy=0 immediately; no response after release; next request (2*3) is granted to requester 0 and returns 6.
5. a0=0, b0=9: with MULT_SCHED_ZERO_BYPASS_EN, rsp_valid after 1 edge with product 0; without it, rsp_valid after 2 edges with product 0.
6. Idle bus: req_valid=00 for 10 cycles → req_ready=00, rsp_valid=0, rr_ptr unchanged; then req_valid=10, a1=15, b1=1 → rsp_id=1, rsp_product=15.

Source files
------------

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin share of one multiplier among R requesters (ports: clk, rst async high, req_valid/req_a/req_b/req_ready per requester, rsp_valid/rsp_id/rsp_product/rsp_ready response, busy; option MULT_SCHED_ZERO_BYPASS_EN)
module multiplier #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) p = b[i] ? p + ((2*N)'(a) << i) : p;
  end
endmodule

module mult_scheduler #(
  parameter int N = 4,
  parameter int R = 2,
  localparam int IW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [IW-1:0]  rsp_id,
  output logic [2*N-1:0] rsp_product,
  input  logic           rsp_ready,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, g, idx, id_r;
  logic [N-1:0] a_r, b_r, a_sel, b_sel;
  logic [2*N-1:0] prod;
  logic any, accept, skip;
  multiplier #(.N(N)) u_mult (.a(a_r), .b(b_r), .p(prod));
  always_comb begin
    g = '0;
    idx = '0;
    any = 1'b0;
    for (int k = R-1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % R);
      if (req_valid[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < R; k++) begin
      a_sel = (g == IW'(k)) ? req_a[k*N +: N] : a_sel;
      b_sel = (g == IW'(k)) ? req_b[k*N +: N] : b_sel;
    end
  end
`ifdef MULT_SCHED_ZERO_BYPASS_EN
  assign skip = (a_sel == '0) || (b_sel == '0);
`else
  assign skip = 1'b0;
`endif
  assign accept = |(req_valid & req_ready);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? (skip ? DONE : EXEC) : IDLE;
      EXEC: nxt = DONE;
      DONE: nxt = rsp_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    for (int k = 0; k < R; k++) req_ready[k] = (state == IDLE) && any && (g == IW'(k));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      a_r <= '0;
      b_r <= '0;
      id_r <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_product <= '0;
    end else begin
      if (accept) begin
        a_r <= a_sel;
        b_r <= b_sel;
        id_r <= g;
        rr_ptr <= IW'((int'(g) + 1) % R);
      end
      if (accept && skip) begin
        rsp_valid <= 1'b1;
        rsp_product <= '0;
        rsp_id <= g;
      end else if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_product <= prod;
        rsp_id <= id_r;
      end else if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: randomized self-checking bench for mult_scheduler with a grant-order/product model
module tb_mult_scheduler;
  logic clk = 0, rst = 1;
  logic [1:0] req_valid = '0, req_ready;
  logic [7:0] req_a = '0, req_b = '0;
  logic rsp_valid, rsp_ready = 0, busy;
  logic [0:0] rsp_id;
  logic [7:0] rsp_product;
  int checks = 0, fails = 0, model_ptr = 0, last_id = -1;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  mult_scheduler #(.N(4), .R(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_ready(rsp_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic transact(input logic [1:0] vm, input int a0, b0, a1, b1, stall, input string tag);
    int g, ea, eb, ep;
    g = -1;
    for (int k = 0; k < 2; k++) if (g < 0 && vm[(model_ptr + k) % 2]) g = (model_ptr + k) % 2;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    ep = ea * eb;
    req_valid = vm;
    req_a = {4'(a1), 4'(a0)};
    req_b = {4'(b1), 4'(b0)};
    rsp_ready = 0;
    #1;
    checks++;
    if (req_ready !== 2'(1 << g)) begin
      fails++;
      $display("FAIL %s grant: req_ready=%b want %b", tag, req_ready, 2'(1 << g));
    end
    tick();
    req_valid = '0;
    req_a = 8'($urandom);
    req_b = 8'($urandom);
    model_ptr = (g + 1) % 2;
    if (!(BYP && (ea == 0 || eb == 0))) begin
      checks++;
      if ({rsp_valid, busy, req_ready} !== 4'b0100) begin
        fails++;
        $display("FAIL %s exec: valid/busy/ready=%b want 0100", tag, {rsp_valid, busy, req_ready});
      end
      rsp_ready = 1'($urandom);
      tick();
      rsp_ready = 0;
    end
    for (int s = 0; s <= stall; s++) begin
      #1;
      checks++;
      if ({rsp_valid, busy, req_ready, rsp_id, rsp_product} !== {1'b1, 1'b1, 2'b00, 1'(g), 8'(ep)}) begin
        fails++;
        $display("FAIL %s done[%0d]: valid=%b busy=%b ready=%b id=%0d prod=%0d want id=%0d prod=%0d",
                 tag, s, rsp_valid, busy, req_ready, rsp_id, rsp_product, g, ep);
      end
      if (s < stall) tick();
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL %s release: valid=%b busy=%b want 0 0", tag, rsp_valid, busy);
    end
    checks++;
    if (last_id == g && vm == 2'b11) begin
      fails++;
      $display("FAIL %s rotation: id %0d granted twice in a row", tag, g);
    end
    last_id = g;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_product, busy, req_ready} !== 13'b0) begin
      fails++;
      $display("FAIL reset: valid=%b id=%0d prod=%0d busy=%b ready=%b want all 0",
               rsp_valid, rsp_id, rsp_product, busy, req_ready);
    end
    rst = 0;
    model_ptr = 0;
    last_id = -1;
  endtask
  task automatic test_basic();
    transact(2'b01, 13, 11, 0, 0, 0, "basic_13x11");
  endtask
  task automatic test_rotation();
    test_reset();
    for (int i = 0; i < 4; i++) transact(2'b11, 15, 15, 3, 5, 0, "rotation");
  endtask
  task automatic test_backpressure();
    transact(2'b01, 6, 7, 0, 0, 5, "backpressure_6x7");
  endtask
  task automatic test_reset_mid();
    req_valid = 2'b01;
    req_a = 8'h09;
    req_b = 8'h09;
    #1;
    tick();
    req_valid = '0;
    rst = 1;
    #1;
    checks++;
    if ({rsp_valid, rsp_product, busy} !== 10'b0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b prod=%0d busy=%b want 0", rsp_valid, rsp_product, busy);
    end
    tick();
    rst = 0;
    model_ptr = 0;
    last_id = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        fails++;
        $display("FAIL reset_mid_after[%0d]: valid=%b busy=%b want 0 0", i, rsp_valid, busy);
      end
    end
    transact(2'b01, 2, 3, 0, 0, 0, "after_reset_2x3");
  endtask
  task automatic test_zero();
    transact(2'b01, 0, 9, 0, 0, 0, "zero_a");
    transact(2'b10, 0, 0, 7, 0, 1, "zero_b");
  endtask
  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({req_ready, rsp_valid, busy} !== 4'b0) begin
        fails++;
        $display("FAIL idle[%0d]: ready=%b valid=%b busy=%b want 0", i, req_ready, rsp_valid, busy);
      end
    end
    transact(2'b11, 4, 5, 6, 7, 0, "idle_ptr_kept");
    transact(2'b10, 0, 0, 15, 1, 0, "idle_then_15x1");
  endtask
  task automatic test_random();
    for (int i = 0; i < 30; i++)
      transact(2'($urandom_range(1, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 2), "random");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
